// File: rtl/rst_seq_pkg.sv
// Shared definitions for the sequenced reset release block: state encoding,
// counter sizing and parameter legality.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter only has to reach max(HOLD_CYCLES, STAGE_GAP)-1; keep at least one bit.
  function automatic int cnt_width(input int hold_cycles, input int stage_gap);
    int w;
    w = $clog2(max2(hold_cycles, stage_gap));
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit params_legal(input int sync_stages, input int hold_cycles,
                                      input int stage_gap, input int num_out);
    return (sync_stages >= 2) && (hold_cycles >= 1) && (stage_gap >= 1) && (num_out >= 1);
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Reset synchronizer: asserts asynchronously with rst_n, deasserts only after
// SYNC_STAGES rising clk edges.
module rst_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_ok
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= '0;
    else        chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_ok = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_release.sv
// Sequenced reset release: synchronizes rst_n deassertion, holds, then releases
// NUM_OUT active-low domain resets one at a time in ascending order.
module rst_seq_release
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int NUM_OUT     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ext_hold,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               ready
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP);
  localparam int IDX_W = $clog2(NUM_OUT) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

  if (!params_legal(SYNC_STAGES, HOLD_CYCLES, STAGE_GAP, NUM_OUT)) begin : g_bad_params
    $error("rst_seq_release: illegal parameter set");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
  logic               ready_q, ready_d;
  logic               sync_ok;
  logic               hold_req;

  rst_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .sync_ok (sync_ok)
  );

  // Soft hold is meaningless while the hard reset path is still asserted.
  assign hold_req = ext_hold && (state_q != S_RESET);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async clear also covers the output flops so rst_out_n
  // drops the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (hold_req) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_RESET: begin
          if (sync_ok) begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end
        end
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = (NUM_OUT == 1) ? S_RUN : S_RELEASE;
            cnt_d   = '0;
            idx_d   = IDX_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) state_d = S_RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: ;
      endcase
    end
  end

  // Next values for the output flops; outputs themselves are pure flop Q.
  always_comb begin
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    if (hold_req) begin
      rst_out_d = '0;
      ready_d   = 1'b0;
    end else begin
      case (state_q)
        S_RESET: begin
          rst_out_d = '0;
          ready_d   = 1'b0;
        end
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rst_out_d[0] = 1'b1;
            ready_d      = (NUM_OUT == 1);
          end
        end
        S_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            for (int i = 0; i < NUM_OUT; i++) begin
              if (idx_q == IDX_W'(i)) rst_out_d[i] = 1'b1;
            end
            if (idx_q == IDX_LAST) ready_d = 1'b1;
          end
        end
        S_RUN: begin
          rst_out_d = '1;
          ready_d   = 1'b1;
        end
      endcase
    end
  end

  assign rst_out_n = rst_out_q;
  assign ready     = ready_q;

endmodule
